pci_dma_rd_engine: RTL and testbench

- AXI-domain read DMA engine that feeds the PCI master read path's AXI slave port (mst_s_ar*/mst_s_r*).
- Accepts one transfer request (64-bit dword address, dword count) and splits it into INCR bursts, each limited by MAX_BURST and by the 4KB boundary.
- Limits the number of outstanding bursts, returns read data as a single stream with one last marker per request, and signals completion with sticky error status.

---
 rtl/pci_dma_rd_engine.sv | 155 +++++++++++++++
 tb/tb_pci_dma_rd_engine.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_dma_rd_engine.sv
// AXI read DMA engine: splits one dword transfer request into MAX_BURST / 4KB-bounded
// INCR bursts, caps outstanding bursts, and returns the data as one stream with completion status.
module pci_dma_rd_engine #(
  parameter logic [3:0]  ID              = 4'd0,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        mst_s_aclk,
  input  logic        mst_s_aresetn,
  input  logic [63:0] req_addr,
  input  logic [15:0] req_len,
  input  logic        req_valid,
  output logic        req_ready,
  output logic [3:0]  mst_s_arid,
  output logic [63:0] mst_s_araddr,
  output logic [7:0]  mst_s_arlen,
  output logic [2:0]  mst_s_arsize,
  output logic [1:0]  mst_s_arburst,
  output logic [3:0]  mst_s_arcache,
  output logic        mst_s_arvalid,
  input  logic        mst_s_arready,
  input  logic [3:0]  mst_s_rid,
  input  logic [31:0] mst_s_rdata,
  input  logic [1:0]  mst_s_rresp,
  input  logic        mst_s_rlast,
  input  logic        mst_s_rvalid,
  output logic        mst_s_rready,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        dout_last,
  input  logic        dout_ready,
  output logic        done,
  output logic        done_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, AR_WAIT, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] addr_q, araddr_q;
  logic [15:0] ar_rem_q, beat_rem_q;
  logic [7:0]  arlen_q;
  logic [3:0]  outst_q;
  logic        arvalid_q, err_q;
  logic [31:0] dout_q;
  logic        dout_valid_q, dout_last_q, done_q, done_err_q;

  logic [10:0] to_4k, cap, burst;
  logic [8:0]  burst_len;
  logic        accept, can_issue, ar_hs, r_hs, r_last_hs;

  logic unused_ok;
  assign unused_ok = ^{mst_s_rid, req_addr[1:0]};

  // Burst = min(remaining, MAX_BURST, dwords left before the next 4KB boundary)
  assign to_4k     = 11'd1024 - {1'b0, addr_q[11:2]};
  assign cap       = (to_4k < 11'(MAX_BURST)) ? to_4k : 11'(MAX_BURST);
  assign burst     = (ar_rem_q < {5'b0, cap}) ? ar_rem_q[10:0] : cap;
  assign burst_len = {1'b0, arlen_q} + 9'd1;

  assign accept    = (state_q == IDLE) && req_valid;
  assign can_issue = outst_q < 4'(MAX_OUTSTANDING);
  assign ar_hs     = arvalid_q && mst_s_arready;
  assign r_hs      = mst_s_rvalid && mst_s_rready;
  assign r_last_hs = r_hs && mst_s_rlast;

  always_ff @(posedge mst_s_aclk or negedge mst_s_aresetn) begin
    if (!mst_s_aresetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = (req_len == 16'd0) ? DONE : ISSUE;
      ISSUE:   if (can_issue) state_d = AR_WAIT;
      AR_WAIT: if (mst_s_arready) state_d = (ar_rem_q == {7'b0, burst_len}) ? DRAIN : ISSUE;
      DRAIN:   if (beat_rem_q == 16'd0 && outst_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    mst_s_rready = !dout_valid_q || dout_ready;
  end

  always_ff @(posedge mst_s_aclk or negedge mst_s_aresetn) begin
    if (!mst_s_aresetn) begin
      addr_q       <= '0;
      araddr_q     <= '0;
      ar_rem_q     <= '0;
      beat_rem_q   <= '0;
      arlen_q      <= '0;
      outst_q      <= '0;
      arvalid_q    <= 1'b0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      done_q       <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      if (r_hs) begin
        dout_q       <= mst_s_rdata;
        dout_valid_q <= 1'b1;
        dout_last_q  <= (beat_rem_q == 16'd1);
        beat_rem_q   <= beat_rem_q - 16'd1;
        if (mst_s_rresp != 2'b00) err_q <= 1'b1;
      end else if (dout_ready) begin
        dout_valid_q <= 1'b0;
        dout_last_q  <= 1'b0;
      end

      if (ar_hs && !r_last_hs)      outst_q <= outst_q + 4'd1;
      else if (!ar_hs && r_last_hs) outst_q <= outst_q - 4'd1;

      if (accept) begin
        addr_q     <= {req_addr[63:2], 2'b00};
        ar_rem_q   <= req_len;
        beat_rem_q <= req_len;
        err_q      <= 1'b0;
      end

      if (state_q == ISSUE && can_issue) begin
        araddr_q  <= addr_q;
        arlen_q   <= 8'(burst - 11'd1);
        arvalid_q <= 1'b1;
      end

      if (state_q == AR_WAIT && ar_hs) begin
        arvalid_q <= 1'b0;
        addr_q    <= addr_q + {53'b0, burst_len, 2'b00};
        ar_rem_q  <= ar_rem_q - {7'b0, burst_len};
      end

      done_q     <= (state_q == DONE);
      done_err_q <= (state_q == DONE) && err_q;
    end
  end

  assign mst_s_arid    = ID;
  assign mst_s_araddr  = araddr_q;
  assign mst_s_arlen   = arlen_q;
  assign mst_s_arsize  = 3'b010;
  assign mst_s_arburst = 2'b01;
  assign mst_s_arcache = 4'b0011;
  assign mst_s_arvalid = arvalid_q;
  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign dout_last     = dout_last_q;
  assign done          = done_q;
  assign done_err      = done_err_q;

endmodule

// File: tb/tb_pci_dma_rd_engine.sv
// Scoreboard bench for pci_dma_rd_engine: behavioural AXI read slave, request-level
// reference model feeding expectation queues, and an independent monitor process.
module tb_pci_dma_rd_engine;

  localparam int MAXB = 16;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic        req_valid, req_ready;
  logic [3:0]  arid, rid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [31:0] rdata, dout;
  logic        rlast, rvalid, rready;
  logic        dout_valid, dout_last, dout_ready, done, done_err;

  pci_dma_rd_engine #(.ID(4'd0), .MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO)) dut (
    .mst_s_aclk(clk), .mst_s_aresetn(rst_n),
    .req_addr(req_addr), .req_len(req_len), .req_valid(req_valid), .req_ready(req_ready),
    .mst_s_arid(arid), .mst_s_araddr(araddr), .mst_s_arlen(arlen), .mst_s_arsize(arsize),
    .mst_s_arburst(arburst), .mst_s_arcache(arcache), .mst_s_arvalid(arvalid),
    .mst_s_arready(arready), .mst_s_rid(rid), .mst_s_rdata(rdata), .mst_s_rresp(rresp),
    .mst_s_rlast(rlast), .mst_s_rvalid(rvalid), .mst_s_rready(rready),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last), .dout_ready(dout_ready),
    .done(done), .done_err(done_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expectation queues (filled by the model at request time)
  logic [63:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  bit          exp_derr[$];
  bit          err_set[logic [63:0]];

  // Slave state
  logic [63:0] s_addr[$];
  int          s_len[$];
  int          s_idx = 0;
  bit          ar_hs_pend = 0, r_hs_pend = 0;
  logic [63:0] pend_addr;
  int          pend_len;
  bit          rnd = 0, r_hold = 0, dr_hold = 0;
  int          r_budget = 0;
  int          ar_count = 0;
  int          outst_tb = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: request -> bursts, beats and completion status
  task automatic push_exp(input logic [63:0] addr, input int len);
    logic [63:0] a;
    int rem, tok, b;
    bit e;
    a = {addr[63:2], 2'b00};
    rem = len;
    while (rem > 0) begin
      tok = (4096 - int'(a[11:0])) / 4;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > tok) b = tok;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(b - 1);
      a = a + 64'(4 * b);
      rem -= b;
    end
    e = 0;
    a = {addr[63:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      exp_data.push_back(data_of(a + 64'(4 * i)));
      exp_last.push_back(i == len - 1);
      if (err_set.exists(a + 64'(4 * i))) e = 1;
    end
    exp_derr.push_back(e);
  endtask

  task automatic issue(input logic [63:0] addr, input int len);
    int n;
    push_exp(addr, len);
    @(negedge clk);
    req_addr = addr;
    req_len = 16'(len);
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 5000) fail_now("req_accept");
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic flush();
    exp_ar_addr.delete(); exp_ar_len.delete();
    exp_data.delete(); exp_last.delete(); exp_derr.delete();
    s_addr.delete(); s_len.delete();
    s_idx = 0; ar_hs_pend = 0; r_hs_pend = 0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_ar_addr.size() + exp_data.size() + exp_derr.size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      fail_now(name);
      flush();
    end
    repeat (3) @(negedge clk);
  endtask

  // AXI read slave: data is a function of the beat address
  initial begin
    logic [63:0] a;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; rid = '0; dout_ready = 0;
    forever begin
      @(negedge clk);
      if (ar_hs_pend) begin
        s_addr.push_back(pend_addr);
        s_len.push_back(pend_len);
      end
      if (r_hs_pend && s_len.size() > 0) begin
        s_idx++;
        if (r_hold && r_budget > 0) r_budget--;
        if (s_idx == s_len[0]) begin
          void'(s_addr.pop_front());
          void'(s_len.pop_front());
          s_idx = 0;
        end
      end
      arready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      dout_ready = dr_hold ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      rid = 4'($urandom);
      if (s_addr.size() > 0 && (!r_hold || r_budget > 0) && (!rnd || $urandom_range(0, 3) != 0)) begin
        a = s_addr[0] + 64'(4 * s_idx);
        rvalid = 1'b1;
        rdata = data_of(a);
        rresp = err_set.exists(a) ? 2'b10 : 2'b00;
        rlast = (s_idx == s_len[0] - 1);
      end else begin
        rvalid = 1'b0;
        rdata = $urandom;
        rresp = 2'b00;
        rlast = 1'b0;
      end
      #1;
      ar_hs_pend = arvalid && arready;
      pend_addr = araddr;
      pend_len = int'(arlen) + 1;
      r_hs_pend = rvalid && rready;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer
  initial begin
    bit          p_ar_stall = 0, p_d_stall = 0;
    logic [63:0] p_araddr;
    logic [7:0]  p_arlen;
    logic [31:0] p_dout;
    logic        p_last;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        p_ar_stall = 0; p_d_stall = 0; outst_tb = 0;
        continue;
      end
      if (p_ar_stall) chk("ar_stable", {arvalid, araddr, arlen}, {1'b1, p_araddr, p_arlen});
      if (p_d_stall) chk("dout_hold", {dout_valid, dout, dout_last}, {1'b1, p_dout, p_last});
      if (arvalid) chk("ar_at_max", 96'(outst_tb >= MAXO), 96'(0));
      if (dout_valid && !dout_ready) chk("rready_low", 96'(rready), 96'(0));
      if (arvalid && arready) begin
        ar_count++;
        chk("ar_const", {arid, arsize, arburst, arcache}, {4'd0, 3'b010, 2'b01, 4'b0011});
        if (exp_ar_addr.size() == 0) fail_now("unexpected_ar");
        else begin
          chk("araddr", araddr, exp_ar_addr.pop_front());
          chk("arlen", 96'(arlen), 96'(exp_ar_len.pop_front()));
        end
      end
      if (dout_valid && dout_ready) begin
        if (exp_data.size() == 0) fail_now("unexpected_dout");
        else chk("dout", {dout_last, dout}, {exp_last.pop_front(), exp_data.pop_front()});
      end
      if (done) begin
        if (exp_derr.size() == 0) fail_now("unexpected_done");
        else chk("done_err", 96'(done_err), 96'(exp_derr.pop_front()));
      end
      if (arvalid && arready) outst_tb++;
      if (rvalid && rready && rlast) outst_tb--;
      p_ar_stall = arvalid && !arready;
      p_araddr = araddr; p_arlen = arlen;
      p_d_stall = dout_valid && !dout_ready;
      p_dout = dout; p_last = dout_last;
    end
  end

  initial begin
    logic [63:0] ra[16];
    int rl[16];
    int c0;
    rst_n = 1'b0;
    req_addr = '0; req_len = '0; req_valid = 1'b0;
    @(negedge clk); #4;
    chk("rst_req_ready", 96'(req_ready), 96'(1));
    chk("rst_arvalid", 96'(arvalid), 96'(0));
    chk("rst_dout", {dout_valid, dout_last, dout}, '0);
    chk("rst_done", {done, done_err}, '0);
    chk("rst_ar", {araddr, arlen}, '0);
    @(negedge clk); #3;
    rst_n = 1'b1;

    issue(64'h1000, 4);   wait_idle("len4");
    issue(64'h0, 40);     wait_idle("len40");
    issue(64'hFF8, 8);    wait_idle("cross4k");
    issue(64'hFFFF_FFF8, 6); wait_idle("carry32");

    // Outstanding cap with R stalled, then one burst released
    r_hold = 1;
    c0 = ar_count;
    issue(64'h10000, 128);
    repeat (40) @(negedge clk);
    #3;
    chk("outst_cap_count", 96'(ar_count - c0), 96'(4));
    chk("outst_cap_arvalid", 96'(arvalid), 96'(0));
    r_budget = 16;
    repeat (40) @(negedge clk);
    #3;
    chk("outst_one_more", 96'(ar_count - c0), 96'(5));
    chk("outst_one_more_arvalid", 96'(arvalid), 96'(0));
    r_hold = 0; r_budget = 0;
    wait_idle("outst");

    issue(64'h2000, 32);
    repeat (6) @(negedge clk);
    dr_hold = 1;
    repeat (10) @(negedge clk);
    dr_hold = 0;
    wait_idle("backpressure");

    err_set[64'h3008] = 1;
    issue(64'h3000, 8); wait_idle("err");
    err_set.delete();
    issue(64'h3000, 8); wait_idle("err_clear");

    // Null transfer: done two cycles after accept, no AR
    c0 = ar_count;
    issue(64'h4000, 0);
    #4;
    chk("len0_done_early", 96'(done), 96'(0));
    @(negedge clk); #4;
    chk("len0_done", {done, done_err}, {1'b1, 1'b0});
    wait_idle("len0");
    chk("len0_no_ar", 96'(ar_count - c0), 96'(0));

    for (int i = 0; i < 16; i++) begin
      ra[i] = {32'($urandom_range(0, 1)), $urandom} & ~64'h3;
      rl[i] = $urandom_range(0, 70);
      if (rl[i] > 0 && $urandom_range(0, 2) == 0)
        err_set[ra[i] + 64'(4 * $urandom_range(0, rl[i] - 1))] = 1;
    end
    rnd = 1;
    for (int i = 0; i < 16; i++) issue(ra[i], rl[i]);
    wait_idle("random");
    rnd = 0;
    err_set.delete();

    // Reset while draining, then a clean request
    r_hold = 1;
    issue(64'h5000, 8);
    repeat (10) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 96'(req_ready), 96'(1));
    chk("mid_rst_ar", {arvalid, araddr, arlen}, '0);
    chk("mid_rst_out", {dout_valid, dout_last, dout, done, done_err}, '0);
    flush();
    r_hold = 0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
    issue(64'h6000, 12); wait_idle("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
